id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS pipeline; sits between decode and execute.
- Captures decoded operands, register specifiers, the instruction func field and control bits each cycle.
- ex_func drives the ALU function decoder directly.
- Implements hazard-unit stall (hold) and flush (bubble insertion), plus a write-back refresh so held operands never go stale.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register specifier width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous active-high reset
- stall  input  1  hold current contents (from hazard unit)
- flush  input  1  replace next contents with bubble
- id_valid  input  1  decode slot holds a real instruction
- id_pc4  input  DATA_W  PC+4 of decode instruction
- id_rd1, id_rd2  input  DATA_W  register file read data (rs, rt)
- id_imm  input  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_AW  register specifiers
- id_func  input  6  instruction func field
- id_ctrl  input  6  {regWrite, memRead, memWrite, memToReg, aluSrc, regDst}
- wb_regWrite  input  1  write-back stage writes register file
- wb_wa  input  REG_AW  write-back destination
- wb_data  input  DATA_W  write-back data
- ex_valid  output  1  execute slot holds a real instruction
- ex_pc4, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered copies
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered copies
- ex_func  output  6  registered func, to ALU function decoder
- ex_ctrl  output  6  registered control bits

Behaviour:
- All outputs registered; latency 1 cycle; all updates on rising clk.
- Reset: clk and rst only; synchronous, active-high.
  - rst=1 at an edge clears every output to 0.
  - ex_func=6'b000000 maps to ALU NOP.
- Priority per edge: rst > flush > stall > load.
- Flush (flush=1, rst=0): bubble.
  - ex_valid=0, ex_ctrl=0, ex_func=0.
  - All data/specifier outputs cleared to 0.
  - flush overrides a simultaneous stall.
- Stall (stall=1, flush=0): every output holds, except the refresh below.
- Load (stall=0, flush=0):
  - If id_valid=1, all id_* fields are captured and ex_valid=1.
  - If id_valid=0, a bubble is loaded (same values as flush).
- WB refresh on load: if wb_regWrite=1, wb_wa!=0 and wb_wa==id_rs, ex_rd1 takes wb_data instead of id_rd1. Same rule for id_rt/ex_rd2.
- WB refresh on stall: if ex_valid=1, wb_regWrite=1, wb_wa!=0 and wb_wa==ex_rs, ex_rd1 takes wb_data. Same rule for ex_rt/ex_rd2.
- Register 0 is never refreshed.
- When rs==rt and both match, both operands are refreshed in the same cycle.
- Reset mid-stall or mid-flush: reset wins, giving the all-zero state on the next edge.
- The block does no arithmetic; fields pass through at full width.

Optional Feature:
- Macro IDEX_STATS_EN.
- When defined, adds outputs stall_cnt and bubble_cnt, each 32 bits, cleared by rst.
  - stall_cnt increments on each edge with stall=1, flush=0, rst=0.
  - bubble_cnt increments on each edge that loads a bubble (flush, or load with id_valid=0).
  - Both counters wrap modulo 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst=1 with id_valid=1, id_func=6'b100000 for one edge -> all outputs 0, ex_func=0, ex_valid=0. Release rst -> next edge captures ex_func=6'b100000, ex_valid=1.
- Load: id_rd1=32'h0000_0005, id_rd2=32'h0000_0003, id_func=6'b100010, id_ctrl=6'b100001 -> one edge later ex_rd1=5, ex_rd2=3, ex_func=6'b100010, ex_ctrl=6'b100001.
- Stall: load ADD, then stall=1 for 3 edges while id_* changes to SUB values -> ex_* stays ADD for 3 edges. Drop stall -> SUB captured on the next edge.
- Flush: flush=1 and stall=1 together with id_valid=1 -> next edge ex_valid=0, ex_ctrl=0, ex_func=0. With IDEX_STATS_EN, bubble_cnt=1 and stall_cnt=0.
- WB refresh on load: id_rs=5'd8, id_rd1=32'h1111_1111, wb_regWrite=1, wb_wa=8, wb_data=32'hDEAD_BEEF -> ex_rd1=32'hDEAD_BEEF. Repeat with wb_wa=0, id_rs=0 -> ex_rd1=id_rd1.
- WB refresh on stall: held ex_rt=5'd9, stall=1, wb write to reg 9 with 32'h0000_00AA -> ex_rd2=32'h0000_00AA after the edge while all other outputs hold.

Source files
------------

// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs, hazard controls,
// write-back refresh port and the registered execute-side outputs.
interface id_ex_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic [5:0]        id_func;
  logic [5:0]        id_ctrl;
  logic              wb_regWrite;
  logic [REG_AW-1:0] wb_wa;
  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic [5:0]        ex_func;
  logic [5:0]        ex_ctrl;

  modport master (
    output stall, flush, id_valid, id_pc4, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, id_func, id_ctrl, wb_regWrite, wb_wa, wb_data,
    input  ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_func, ex_ctrl
  );

  modport slave (
    input  stall, flush, id_valid, id_pc4, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, id_func, id_ctrl, wb_regWrite, wb_wa, wb_data,
    output ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_func, ex_ctrl
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and write-back operand refresh.
// Optional IDEX_STATS_EN adds stall_cnt / bubble_cnt event counters.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  id_ex_reg_if.slave  bus
`ifdef IDEX_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [5:0]        func_q, func_d;
  logic [5:0]        ctrl_q, ctrl_d;
  logic              bubble_s;
  logic              hold_s;

  // Register 0 is hard-wired, so a write-back to it never refreshes an operand.
  function automatic logic wb_hit(input logic we, input logic [REG_AW-1:0] wa,
                                  input logic [REG_AW-1:0] src);
    return we && (wa != {REG_AW{1'b0}}) && (wa == src);
  endfunction

  assign bubble_s = bus.flush || (!bus.stall && !bus.id_valid);
  assign hold_s   = !bus.flush && bus.stall;

  always_comb begin
    valid_d = valid_q;
    pc4_d   = pc4_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    func_d  = func_q;
    ctrl_d  = ctrl_q;
    if (bubble_s) begin
      valid_d = 1'b0;
      pc4_d   = {DATA_W{1'b0}};
      rd1_d   = {DATA_W{1'b0}};
      rd2_d   = {DATA_W{1'b0}};
      imm_d   = {DATA_W{1'b0}};
      rs_d    = {REG_AW{1'b0}};
      rt_d    = {REG_AW{1'b0}};
      rd_d    = {REG_AW{1'b0}};
      func_d  = 6'b000000;
      ctrl_d  = 6'b000000;
    end else if (hold_s) begin
      // Held operands keep tracking write-back so they are current when the stall lifts.
      if (valid_q && wb_hit(bus.wb_regWrite, bus.wb_wa, rs_q)) begin
        rd1_d = bus.wb_data;
      end else begin
        rd1_d = rd1_q;
      end
      if (valid_q && wb_hit(bus.wb_regWrite, bus.wb_wa, rt_q)) begin
        rd2_d = bus.wb_data;
      end else begin
        rd2_d = rd2_q;
      end
    end else begin
      valid_d = 1'b1;
      pc4_d   = bus.id_pc4;
      imm_d   = bus.id_imm;
      rs_d    = bus.id_rs;
      rt_d    = bus.id_rt;
      rd_d    = bus.id_rd;
      func_d  = bus.id_func;
      ctrl_d  = bus.id_ctrl;
      rd1_d   = wb_hit(bus.wb_regWrite, bus.wb_wa, bus.id_rs) ? bus.wb_data : bus.id_rd1;
      rd2_d   = wb_hit(bus.wb_regWrite, bus.wb_wa, bus.id_rt) ? bus.wb_data : bus.id_rd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc4_q   <= {DATA_W{1'b0}};
      rd1_q   <= {DATA_W{1'b0}};
      rd2_q   <= {DATA_W{1'b0}};
      imm_q   <= {DATA_W{1'b0}};
      rs_q    <= {REG_AW{1'b0}};
      rt_q    <= {REG_AW{1'b0}};
      rd_q    <= {REG_AW{1'b0}};
      func_q  <= 6'b000000;
      ctrl_q  <= 6'b000000;
    end else begin
      valid_q <= valid_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      func_q  <= func_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.ex_valid = valid_q;
  assign bus.ex_pc4   = pc4_q;
  assign bus.ex_rd1   = rd1_q;
  assign bus.ex_rd2   = rd2_q;
  assign bus.ex_imm   = imm_q;
  assign bus.ex_rs    = rs_q;
  assign bus.ex_rt    = rt_q;
  assign bus.ex_rd    = rd_q;
  assign bus.ex_func  = func_q;
  assign bus.ex_ctrl  = ctrl_q;

`ifdef IDEX_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = hold_s   ? stall_cnt_q + 32'd1  : stall_cnt_q;
    bubble_cnt_d = bubble_s ? bubble_cnt_q + 32'd1 : bubble_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; counter checks are active with IDEX_STATS_EN.
module tb_id_ex_reg;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  id_ex_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef IDEX_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  id_ex_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef IDEX_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [31:0] rd1, input logic [31:0] rd2,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [5:0] func, input logic [5:0] ctrl);
    bus.id_valid = 1'b1;
    bus.id_pc4   = 32'h0000_1004;
    bus.id_imm   = 32'hFFFF_FFF0;
    bus.id_rd1   = rd1;
    bus.id_rd2   = rd2;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = 5'd7;
    bus.id_func  = func;
    bus.id_ctrl  = ctrl;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.wb_regWrite = 1'b0;
    bus.wb_wa = 5'd0;
    bus.wb_data = 32'h0000_0000;
    drive_id(32'h0000_0001, 32'h0000_0002, 5'd1, 5'd2, 6'b100000, 6'b100001);

    // Reset wins over a valid decode slot
    step();
    check("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_func",  {26'd0, bus.ex_func}, 32'd0);
    check("rst_ctrl",  {26'd0, bus.ex_ctrl}, 32'd0);
    check("rst_rd1",   bus.ex_rd1, 32'd0);
    check("rst_pc4",   bus.ex_pc4, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_func",  {26'd0, bus.ex_func}, 32'h0000_0020);
    check("post_rst_valid", {31'd0, bus.ex_valid}, 32'd1);

    // Plain load
    drive_id(32'h0000_0005, 32'h0000_0003, 5'd1, 5'd2, 6'b100010, 6'b100001);
    step();
    check("load_rd1",  bus.ex_rd1, 32'h0000_0005);
    check("load_rd2",  bus.ex_rd2, 32'h0000_0003);
    check("load_func", {26'd0, bus.ex_func}, 32'h0000_0022);
    check("load_ctrl", {26'd0, bus.ex_ctrl}, 32'h0000_0021);
    check("load_imm",  bus.ex_imm, 32'hFFFF_FFF0);
    check("load_rd",   {27'd0, bus.ex_rd}, 32'd7);

    // Stall holds ADD while SUB waits in decode
    drive_id(32'h0000_000A, 32'h0000_000B, 5'd3, 5'd4, 6'b100000, 6'b100001);
    step();
    drive_id(32'h0000_0014, 32'h0000_0015, 5'd5, 5'd6, 6'b100010, 6'b000011);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_func", {26'd0, bus.ex_func}, 32'h0000_0020);
      check("stall_rd1",  bus.ex_rd1, 32'h0000_000A);
      check("stall_rs",   {27'd0, bus.ex_rs}, 32'd3);
    end
    bus.stall = 1'b0;
    step();
    check("unstall_func", {26'd0, bus.ex_func}, 32'h0000_0022);
    check("unstall_rd1",  bus.ex_rd1, 32'h0000_0014);
    check("unstall_ctrl", {26'd0, bus.ex_ctrl}, 32'h0000_0003);

    // Flush overrides stall; counters start from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    check("flush_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("flush_ctrl",  {26'd0, bus.ex_ctrl}, 32'd0);
    check("flush_func",  {26'd0, bus.ex_func}, 32'd0);
    check("flush_rd1",   bus.ex_rd1, 32'd0);
`ifdef IDEX_STATS_EN
    check("flush_bubble_cnt", bubble_cnt, 32'd1);
    check("flush_stall_cnt",  stall_cnt, 32'd0);
`endif
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // WB refresh on load: rs hit, rt untouched
    drive_id(32'h1111_1111, 32'h2222_2222, 5'd8, 5'd3, 6'b100000, 6'b100001);
    bus.wb_regWrite = 1'b1;
    bus.wb_wa = 5'd8;
    bus.wb_data = 32'hDEAD_BEEF;
    step();
    check("wbload_rd1", bus.ex_rd1, 32'hDEAD_BEEF);
    check("wbload_rd2", bus.ex_rd2, 32'h2222_2222);
    // Register 0 never refreshed
    drive_id(32'h1111_1111, 32'h2222_2222, 5'd0, 5'd3, 6'b100000, 6'b100001);
    bus.wb_wa = 5'd0;
    step();
    check("wbload_r0_rd1", bus.ex_rd1, 32'h1111_1111);
    // rs == rt both refreshed
    drive_id(32'h1111_1111, 32'h2222_2222, 5'd12, 5'd12, 6'b100000, 6'b100001);
    bus.wb_wa = 5'd12;
    bus.wb_data = 32'h0BAD_F00D;
    step();
    check("wbload_same_rd1", bus.ex_rd1, 32'h0BAD_F00D);
    check("wbload_same_rd2", bus.ex_rd2, 32'h0BAD_F00D);

    // WB refresh on stall
    bus.wb_regWrite = 1'b0;
    drive_id(32'h0000_0044, 32'h0000_0055, 5'd4, 5'd9, 6'b100100, 6'b100011);
    step();
    drive_id(32'h0000_0066, 32'h0000_0077, 5'd1, 5'd2, 6'b100101, 6'b000000);
    bus.stall = 1'b1;
    bus.wb_regWrite = 1'b1;
    bus.wb_wa = 5'd9;
    bus.wb_data = 32'h0000_00AA;
    step();
    check("wbstall_rd2",  bus.ex_rd2, 32'h0000_00AA);
    check("wbstall_rd1",  bus.ex_rd1, 32'h0000_0044);
    check("wbstall_rt",   {27'd0, bus.ex_rt}, 32'd9);
    check("wbstall_func", {26'd0, bus.ex_func}, 32'h0000_0024);
    check("wbstall_ctrl", {26'd0, bus.ex_ctrl}, 32'h0000_0023);
`ifdef IDEX_STATS_EN
    check("wbstall_stall_cnt", stall_cnt, 32'd1);
`endif
    bus.wb_regWrite = 1'b0;

    // Reset mid-stall clears everything
    rst = 1'b1;
    step();
    check("rst_stall_rd2",   bus.ex_rd2, 32'd0);
    check("rst_stall_valid", {31'd0, bus.ex_valid}, 32'd0);
    rst = 1'b0;
    bus.stall = 1'b0;

    // Load with id_valid=0 yields a bubble
    step();
    check("reload_valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.id_valid = 1'b0;
    step();
    check("idinv_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("idinv_func",  {26'd0, bus.ex_func}, 32'd0);
    check("idinv_rd1",   bus.ex_rd1, 32'd0);
`ifdef IDEX_STATS_EN
    check("idinv_bubble_cnt", bubble_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
